instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Consumer side of the PC: reads instruction memory at the current fetch PC over a req/ack
//  handshake and buffers {pc, instr} pairs for decode. Takes the same redirect (pc_sel/alu_out)
//  as the PC: flushes its buffer, drops any in-flight response, restarts at the target.
//  Sits between the PC/branch logic and decode.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              fetch-buffer entries (>=1)
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  reset       in   1   synchronous, active-high reset
//  pc_sel      in   1   redirect strobe (branch/jump taken)
//  alu_out     in   32  redirect target
//  imem_req    out  1   read request; held until imem_ack
//  imem_addr   out  32  read address; stable while imem_req=1
//  imem_ack    in   1   response strobe, valid only while imem_req=1
//  imem_rdata  in   32  instruction word, valid with imem_ack
//  if_valid    out  1   buffer head valid
//  if_pc       out  32  PC of head entry
//  if_instr    out  32  instruction of head entry
//  if_ready    in   1   decode accepts head (pop when if_valid && if_ready)
//  misalign_fault out 1 sticky misaligned-redirect flag (0 unless IFU_MISALIGN_TRAP_EN)
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=RESET_PC, buffer empty; imem_req=0, imem_addr=RESET_PC,
//   if_valid=0, if_pc=0, if_instr=0, misalign_fault=0. Reset overrides every other input.
//  Outputs imem_req/imem_addr are registered (driven from state/fetch_pc).
//  Space: space = (count_after_this_edge < FIFO_DEPTH); a same-cycle pop counts.
//  FSM states IDLE, BUSY (request outstanding, response kept), DROP (outstanding, discard):
//   IDLE: space && !pc_sel -> BUSY, imem_addr<=fetch_pc.
//   BUSY, ack, !pc_sel: push {imem_addr, imem_rdata}; fetch_pc+=4; next request issued
//    back-to-back if space (stay BUSY, new addr) else IDLE. One outstanding request max.
//   BUSY, !ack, pc_sel: -> DROP; imem_req/imem_addr held unchanged (protocol stability).
//   BUSY, ack, pc_sel: response discarded, -> IDLE.
//   DROP, ack: discard, -> IDLE. DROP, pc_sel: update target, stay DROP.
//  Redirect (pc_sel=1) in any state: fetch_pc<=target, buffer flushed same edge; if_valid=0
//   next cycle; flush wins over a same-cycle push or pop.
//  Latency: zero-wait memory (ack=1 whenever req=1): first request one cycle after reset
//   release; entry visible on if_valid the cycle after its ack; steady 1 instr/cycle.
//  Redirect-to-first-request: 1 cycle from IDLE; after DROP, 1 cycle after the dropped ack.
//  Full buffer: imem_req deasserts after the current ack; no request is ever issued without space.
//  Arithmetic: fetch_pc+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
//  Pushing an instruction implies no pop of the same entry in that cycle (no bypass).
// CONFIGURATION
//  IFU_MISALIGN_TRAP_EN defined: a redirect target with [1:0]!=0 sets misalign_fault (sticky),
//   flushes, and halts fetch (no imem_req) until reset or an aligned redirect clears it.
//  Not defined: target[1:0] forced to 2'b00 and fetch continues; misalign_fault tied 0.
// TESTING
//  1 reset, ack=1 always, if_ready=1, rdata=addr^32'hA5A5_0000 -> if_pc 0x0,0x4,0x8,0xC, if_instr matches
//  2 if_ready=0 -> two entries (0x0,0x4), imem_req drops, no 3rd req; if_ready=1 -> resumes 0x8
//  3 request to 0x8 with ack delayed 3 cycles, pc_sel=1/alu_out=0x1000 mid-wait -> imem_addr
//    holds 0x8 until ack, data dropped; next if_pc 0x1000, 0x1004
//  4 redirect to 0x203 -> no macro: if_pc 0x200, 0x204; macro: misalign_fault=1, imem_req=0,
//    then redirect to 0x2000 clears fault, if_pc 0x2000
//  5 reset asserted in BUSY with 1 buffered entry -> next cycle if_valid=0, imem_req=0;
//    after release first imem_addr=RESET_PC
//  6 redirect to 0xFFFFFFFC -> if_pc 0xFFFFFFFC then 0x00000000; pc_sel coincident with
//    ack and pop -> buffer empty, next if_pc = target

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues imem reads at the fetch PC and buffers {pc, instr} for decode.
// Optional IFU_MISALIGN_TRAP_EN: misaligned redirect targets raise a sticky fault and halt fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_sel,
  input  logic [31:0] alu_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        misalign_fault
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_after;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]        buf_pc_q    [FIFO_DEPTH];
  logic [31:0]        buf_instr_q [FIFO_DEPTH];
  logic [31:0]        redirect_pc;
  logic               halt, push, pop, space;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign redirect_pc = alu_out;

  always_comb begin
    fault_d = fault_q;
    if (pc_sel) fault_d = (alu_out[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign halt           = fault_q;
  assign misalign_fault = fault_q;
`else
  assign redirect_pc    = alu_out & 32'hFFFF_FFFC;
  assign halt           = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // imem handshake: imem_req and imem_addr are registered and held stable until the
  // cycle imem_ack is seen high; a transfer completes on a posedge with req && ack.
  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;

  assign push = (state_q == BUSY) && imem_ack && !pc_sel;
  assign pop  = (cnt_q != '0) && if_ready;

  // Space is judged on the occupancy after this edge so a pop frees a slot immediately.
  always_comb begin
    cnt_after = cnt_q + CNT_W'(push) - CNT_W'(pop);
    space     = (cnt_after < CNT_W'(FIFO_DEPTH));
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    if (pc_sel)    fetch_pc_d = redirect_pc;
    else if (push) fetch_pc_d = fetch_pc_q + 32'd4;
    case (state_q)
      IDLE: begin
        if (!pc_sel && space && !halt) begin
          state_d = BUSY;
          addr_d  = fetch_pc_q;
        end
      end
      BUSY: begin
        if (imem_ack) begin
          if (!pc_sel && space && !halt) addr_d  = fetch_pc_d;
          else                           state_d = IDLE;
        end else if (pc_sel) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_after;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    if (pc_sel) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= addr_q;
      buf_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign if_valid = (cnt_q != '0);
  assign if_pc    = if_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
  assign if_instr = if_valid ? buf_instr_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model (fetch pointer, outstanding flag, entry queue).
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

  logic        clk, reset, pc_sel, imem_ack, if_ready;
  logic [31:0] alu_out, imem_rdata;
  logic        imem_req, if_valid, misalign_fault;
  logic [31:0] imem_addr, if_pc, if_instr;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_sel(pc_sel), .alu_out(alu_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_ready(if_ready), .misalign_fault(misalign_fault)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic ack_hold = 1'b0;
  logic ack_rand = 1'b0;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    #2;
    imem_ack   = imem_req && !ack_hold && (ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    imem_rdata = imem_addr ^ MEM_KEY;
  end

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];
  logic        m_live = 1'b0;
  logic        m_rst  = 1'b0;
  logic        m_req, m_drop, m_fault;
  logic [31:0] m_addr, m_pc;

  always @(posedge clk) begin
    logic        popped, keep, issue;
    logic [31:0] tgt;
    if (reset) begin
      exp_q.delete();
      m_req = 1'b0; m_drop = 1'b0; m_fault = 1'b0;
      m_addr = RESET_PC; m_pc = RESET_PC;
      m_live = 1'b1; m_rst = 1'b1;
    end else if (m_live) begin
      m_rst  = 1'b0;
      popped = (exp_q.size() > 0) && if_ready;
      keep   = m_req && imem_ack && !m_drop && !pc_sel;
`ifdef IFU_MISALIGN_TRAP_EN
      tgt = alu_out;
`else
      tgt = {alu_out[31:2], 2'b00};
`endif
      if (pc_sel) exp_q.delete();
      else begin
        if (popped) void'(exp_q.pop_front());
        if (keep)   exp_q.push_back({m_addr, imem_rdata});
      end
      if (pc_sel) begin
        m_pc = tgt;
`ifdef IFU_MISALIGN_TRAP_EN
        m_fault = (alu_out[1:0] != 2'b00);
`endif
      end else if (keep) m_pc = m_pc + 32'd4;
      if (m_req && !imem_ack) begin
        if (pc_sel) m_drop = 1'b1;
      end else begin
        issue  = !pc_sel && !m_fault && (exp_q.size() < DEPTH) && (!m_req || keep);
        m_req  = issue;
        m_drop = 1'b0;
        if (issue) m_addr = m_pc;
      end
    end
  end

  // ---------------- scoreboard compare + delivery log ----------------
  logic [63:0] log_q[$];
  int          hs_cnt = 0;

  always @(negedge clk) begin
    if (m_live) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      check("imem_addr", imem_addr, m_addr);
      check("if_valid", {31'b0, if_valid}, {31'b0, exp_q.size() > 0});
      check("misalign_fault", {31'b0, misalign_fault}, {31'b0, m_fault});
      if (exp_q.size() > 0) begin
        check("if_pc", if_pc, exp_q[0][63:32]);
        check("if_instr", if_instr, exp_q[0][31:0]);
      end else if (m_rst) begin
        check("if_pc_rst", if_pc, 32'h0);
        check("if_instr_rst", if_instr, 32'h0);
      end
    end
    if (if_valid && if_ready) log_q.push_back({if_pc, if_instr});
    if (imem_req && imem_ack) hs_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    pc_sel  = 1'b1;
    alu_out = tgt;
    cyc(1);
    pc_sel  = 1'b0;
  endtask

  task automatic check_log(input int idx, input logic [31:0] exp_pc);
    if (idx >= log_q.size()) begin
      check($sformatf("log[%0d] present", idx), 32'd0, 32'd1);
    end else begin
      check($sformatf("log[%0d].pc", idx), log_q[idx][63:32], exp_pc);
      check($sformatf("log[%0d].instr", idx), log_q[idx][31:0], exp_pc ^ MEM_KEY);
    end
  endtask

  task automatic wait_for_busy_with_entry(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (if_valid && imem_req) found = 1'b1;
    end
    check(name, {31'b0, found}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    reset = 1'b1; pc_sel = 1'b0; alu_out = 32'h0; if_ready = 1'b1;
    cyc(2);
    check("rst imem_req", {31'b0, imem_req}, 32'd0);
    check("rst imem_addr", imem_addr, RESET_PC);
    check("rst if_valid", {31'b0, if_valid}, 32'd0);
    check("rst if_pc", if_pc, 32'h0);
    check("rst misalign", {31'b0, misalign_fault}, 32'd0);

    // 1: streaming fetch from reset
    reset = 1'b0;
    log_q.delete();
    cyc(8);
    check_log(0, 32'h0); check_log(1, 32'h4); check_log(2, 32'h8); check_log(3, 32'hC);

    // 2: decode stalled, buffer fills and requests stop
    if_ready = 1'b0;
    do_reset();
    log_q.delete();
    hs_cnt = 0;
    cyc(10);
    check("full handshakes", hs_cnt, 32'd2);
    check("full imem_req", {31'b0, imem_req}, 32'd0);
    check("full if_valid", {31'b0, if_valid}, 32'd1);
    check("full if_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    cyc(8);
    check_log(0, 32'h0); check_log(1, 32'h4); check_log(2, 32'h8);

    // 3: redirect while a request to 0x8 waits for a late ack
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    check("req to 0x8 seen", {31'b0, found}, 32'd1);
    ack_hold = 1'b1;
    cyc(1);
    redirect(32'h1000);
    log_q.delete();
    check("drop hold req", {31'b0, imem_req}, 32'd1);
    check("drop hold addr", imem_addr, 32'h8);
    cyc(1);
    check("drop hold addr 2", imem_addr, 32'h8);
    ack_hold = 1'b0;
    cyc(10);
    check_log(0, 32'h1000); check_log(1, 32'h1004);

    // 4: misaligned redirect target
    redirect(32'h203);
    log_q.delete();
`ifdef IFU_MISALIGN_TRAP_EN
    check("fault set", {31'b0, misalign_fault}, 32'd1);
    cyc(3);
    check("fault halts req", {31'b0, imem_req}, 32'd0);
    check("fault if_valid", {31'b0, if_valid}, 32'd0);
    redirect(32'h2000);
    log_q.delete();
    check("fault cleared", {31'b0, misalign_fault}, 32'd0);
    cyc(8);
    check_log(0, 32'h2000); check_log(1, 32'h2004);
`else
    cyc(8);
    check_log(0, 32'h200); check_log(1, 32'h204);
    check("no fault", {31'b0, misalign_fault}, 32'd0);
`endif

    // 5: reset while busy with one entry buffered
    if_ready = 1'b0;
    do_reset();
    wait_for_busy_with_entry("busy with entry");
    reset = 1'b1;
    cyc(1);
    check("mid rst if_valid", {31'b0, if_valid}, 32'd0);
    check("mid rst imem_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b0;
    cyc(1);
    check("post rst req", {31'b0, imem_req}, 32'd1);
    check("post rst addr", imem_addr, RESET_PC);
    if_ready = 1'b1;

    // 6: wraparound, then redirect coincident with ack and pop
    redirect(32'hFFFF_FFFC);
    log_q.delete();
    cyc(8);
    check_log(0, 32'hFFFF_FFFC); check_log(1, 32'h0000_0000);
    wait_for_busy_with_entry("steady before coincident");
    check("coincident ack", {31'b0, imem_ack}, 32'd1);
    redirect(32'h3000);
    check("flush if_valid", {31'b0, if_valid}, 32'd0);
    log_q.delete();
    cyc(6);
    check_log(0, 32'h3000);

    // randomized traffic against the model
    ack_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      pc_sel   = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 3))
        0:       alu_out = $urandom;
        1:       alu_out = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        2:       alu_out = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
        default: alu_out = 32'h100 + 32'($urandom_range(0, 3));
      endcase
      cyc(1);
    end
    reset    = 1'b0;
    pc_sel   = 1'b0;
    ack_rand = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
